// File: rtl/flag_counter_pkg.sv
// Shared width and type for the flag_counter timing source.
package flag_counter_pkg;
  localparam int CNT_WIDTH = 4;
  typedef logic [CNT_WIDTH-1:0] cnt_t;
endpackage

// File: rtl/flag_counter.sv
// Free-running up-counter that loads a programmable start value on the first
// clock edge after reset release, then increments by one every edge.
module flag_counter
  import flag_counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] cntStart,
  output logic [WIDTH-1:0] cnt
);

  logic load_pending;

  // Reset re-arms the load; the count wraps silently at all-ones.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt          <= '0;
      load_pending <= 1'b1;
    end else if (load_pending) begin
      cnt          <= cntStart;
      load_pending <= 1'b0;
    end else begin
      cnt          <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_flag_counter.sv
// Directed bench for flag_counter: stimulus queues hand-computed counts and a
// separate monitor pops and compares them against the DUT output.
module tb_flag_counter;
  import flag_counter_pkg::*;

  logic clk;
  logic rstn;
  cnt_t cntStart;
  cnt_t cnt;

  typedef struct {
    string name;
    cnt_t  val;
  } exp_t;

  exp_t exp_q[$];
  event ev_push;
  int   checks;
  int   errors;

  flag_counter #(.WIDTH(CNT_WIDTH)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .cntStart (cntStart),
    .cnt      (cnt)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic expect_cnt(input string name, input cnt_t val);
    exp_t e;
    checks++;
    if (cnt !== val) begin
      errors++;
      $display("FAIL %s (direct) at %0t: cnt=%0d expected %0d", name, $time, cnt, val);
    end
    e.name = name;
    e.val  = val;
    exp_q.push_back(e);
    -> ev_push;
  endtask

  // Expectation for the value present just after the next rising edge.
  task automatic edge_expect(input string name, input cnt_t val);
    @(posedge clk);
    #1;
    expect_cnt(name, val);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(ev_push);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (cnt !== e.val) begin
          errors++;
          $display("FAIL %s at %0t: cnt=%0d expected %0d", e.name, $time, cnt, e.val);
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;

    // Power-up: reset 0..20, start value 0 loaded at edge 30
    rstn = 1'b0;
    cntStart = 4'd0;
    #5;
    expect_cnt("por_hold", 4'd0);
    edge_expect("por_edge_in_reset", 4'd0);
    #9;
    rstn = 1'b1;
    for (int k = 0; k < 10; k++) edge_expect("por_count", cnt_t'(k));

    // Mid-run reset at 230, release at 240, load 1 at edge 250
    #19;
    cntStart = 4'd1;
    rstn = 1'b0;
    #1;
    expect_cnt("mid_async_clear", 4'd0);
    #9;
    rstn = 1'b1;
    for (int k = 1; k <= 10; k++) edge_expect("mid_count", cnt_t'(k));

    // Wrap-around from 15 to 0
    #4;
    rstn = 1'b0;
    cntStart = 4'd14;
    #1;
    expect_cnt("wrap_reset", 4'd0);
    #4;
    rstn = 1'b1;
    edge_expect("wrap_load", 4'd14);
    edge_expect("wrap_15", 4'd15);
    edge_expect("wrap_0", 4'd0);
    edge_expect("wrap_1", 4'd1);

    // cntStart changes while counting are ignored
    #4;
    rstn = 1'b0;
    cntStart = 4'd3;
    #5;
    rstn = 1'b1;
    edge_expect("chg_load", 4'd3);
    edge_expect("chg_inc", 4'd4);
    cntStart = 4'd9;
    edge_expect("chg_ignored", 4'd5);
    edge_expect("chg_ignored", 4'd6);
    edge_expect("chg_ignored", 4'd7);

    // Async reset between edges while cnt=5
    #4;
    rstn = 1'b0;
    cntStart = 4'd4;
    #5;
    rstn = 1'b1;
    edge_expect("async_load", 4'd4);
    edge_expect("async_pre", 4'd5);
    cntStart = 4'd7;
    #4;
    rstn = 1'b0;
    #1;
    expect_cnt("async_clear", 4'd0);
    #4;
    rstn = 1'b1;
    edge_expect("async_reload", 4'd7);
    edge_expect("async_inc", 4'd8);

    // Reset released exactly on a rising edge: that edge does not load
    #4;
    rstn = 1'b0;
    cntStart = 4'd12;
    #1;
    expect_cnt("rel_edge_reset", 4'd0);
    @(posedge clk);
    rstn <= 1'b1;
    #1;
    expect_cnt("rel_edge_noload", 4'd0);
    edge_expect("rel_edge_load", 4'd12);
    edge_expect("rel_edge_inc", 4'd13);

    // Reset asserted exactly on a rising edge: reset wins
    @(posedge clk);
    rstn = 1'b0;
    #1;
    expect_cnt("assert_edge", 4'd0);
    edge_expect("assert_hold", 4'd0);
    #9;
    rstn = 1'b1;
    edge_expect("assert_reload", 4'd12);

    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending expectations: %0d left unchecked", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL watchdog: time=%0t limit=%0d", $time, 20000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
